// File: rtl/usb_pkg.sv
// usb_pkg: CRC16 constants and the transmit FSM state type shared by the CRC blocks.
package usb_pkg;
  localparam logic [15:0] crc_poly = 16'hA001;
  localparam logic [15:0] crc_init = 16'hFFFF;
  typedef enum logic [1:0] {IDLE, DATA, CRC_LO, CRC_HI} state_t;
endpackage

// File: rtl/crc16_t_if.sv
// crc16_t_if: upstream (tx_lt_*) and downstream (tx_lp_*) byte streams around the CRC appender.
interface crc16_t_if;
  logic       tx_lt_sop, tx_lt_eop, tx_lt_valid, tx_lt_ready, tx_lt_cancle;
  logic [7:0] tx_lt_data;
  logic       tx_lp_sop, tx_lp_eop, tx_lp_valid, tx_lp_ready, tx_lp_cancle;
  logic [7:0] tx_lp_data;
  modport slave (
    input  tx_lt_sop, tx_lt_eop, tx_lt_valid, tx_lt_data, tx_lt_cancle, tx_lp_ready,
    output tx_lt_ready, tx_lp_sop, tx_lp_eop, tx_lp_valid, tx_lp_data, tx_lp_cancle
  );
  modport master (
    output tx_lt_sop, tx_lt_eop, tx_lt_valid, tx_lt_data, tx_lt_cancle, tx_lp_ready,
    input  tx_lt_ready, tx_lp_sop, tx_lp_eop, tx_lp_valid, tx_lp_data, tx_lp_cancle
  );
endinterface

// File: rtl/crc16_byte.sv
// crc16_byte: next USB CRC16 register value after one byte, LSB first, reflected polynomial.
module crc16_byte
  import usb_pkg::*;
(
  input  logic [15:0] crc,
  input  logic [7:0]  data,
  output logic [15:0] crc_next
);
  always_comb begin
    crc_next = crc;
    for (int i = 0; i < 8; i++)
      crc_next = (crc_next >> 1) ^ ((crc_next[0] ^ data[i]) ? crc_poly : 16'h0000);
  end
endmodule

// File: rtl/crc16_t.sv
// crc16_t: forwards a packet downstream and appends the inverted CRC16 of its payload.
module crc16_t
  import usb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  crc16_t_if.slave    bus,
  output logic        crc_busy
);
  state_t      state;
  logic [15:0] crc, crc_next;
  logic        hs, lp_valid, fwd;
  crc16_byte u_crc (.crc(crc), .data(bus.tx_lt_data), .crc_next(crc_next));
  assign fwd      = state == IDLE || state == DATA;
  assign hs       = bus.tx_lt_valid & bus.tx_lt_ready;
  assign crc_busy = state == CRC_LO || state == CRC_HI;
  // outputs are gated by rst_n so everything reads zero while reset is held
  always_comb begin
    bus.tx_lt_ready  = fwd ? bus.tx_lp_ready : 1'b0;
    lp_valid         = (!rst_n || bus.tx_lt_cancle) ? 1'b0 :
                       state == IDLE ? bus.tx_lt_valid & bus.tx_lt_sop :
                       state == DATA ? bus.tx_lt_valid : 1'b1;
    bus.tx_lp_valid  = lp_valid;
    bus.tx_lp_sop    = lp_valid & fwd & bus.tx_lt_sop;
    bus.tx_lp_eop    = lp_valid & (state == IDLE ? bus.tx_lt_eop : state == CRC_HI);
    bus.tx_lp_data   = !lp_valid ? 8'h00 :
                       state == CRC_LO ? ~crc[7:0] :
                       state == CRC_HI ? ~crc[15:8] : bus.tx_lt_data;
    bus.tx_lp_cancle = rst_n & bus.tx_lt_cancle;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      crc   <= crc_init;
    end else if (bus.tx_lt_cancle) begin
      state <= IDLE;
      crc   <= crc_init;
    end else begin
      case (state)
        IDLE:
          if (hs && bus.tx_lt_sop && !bus.tx_lt_eop) begin
            state <= DATA;
            crc   <= crc_init;
          end
        DATA:
          if (hs && bus.tx_lt_sop) crc <= crc_init;
          else if (hs) begin
            crc <= crc_next;
            if (bus.tx_lt_eop) state <= CRC_LO;
          end else if (!bus.tx_lt_valid && bus.tx_lt_eop) state <= CRC_LO;
        CRC_LO: if (bus.tx_lp_ready) state <= CRC_HI;
        CRC_HI: if (bus.tx_lp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_crc16_t.sv
// tb_crc16_t: directed and randomized packets checked against a plain CRC16 reference.
module tb_crc16_t;
  typedef logic [9:0] cap_q_t[$];
  logic clk = 0, rst_n = 0, crc_busy;
  int   tests = 0, fails = 0;
  bit   stall_en = 0, rdy_fixed = 1, held = 0;
  logic [7:0] hold_d;
  cap_q_t cap;
  crc16_t_if bus ();
  crc16_t dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave), .crc_busy(crc_busy));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1;
    bus.tx_lp_ready = stall_en ? ($urandom_range(0, 3) != 0) : rdy_fixed;
  end
  always @(negedge clk) begin
    if (held && rst_n) begin
      tests++;
      assert (bus.tx_lp_valid === 1'b1 && bus.tx_lp_data === hold_d) else begin
        fails++;
        $error("FAIL stall_hold: valid=%b data=%h expected valid=1 data=%h", bus.tx_lp_valid, bus.tx_lp_data, hold_d);
      end
    end
    held   = bus.tx_lp_valid === 1'b1 && bus.tx_lp_ready === 1'b0;
    hold_d = bus.tx_lp_data;
    if (bus.tx_lp_valid === 1'b1 && bus.tx_lp_ready === 1'b1)
      cap.push_back({bus.tx_lp_sop, bus.tx_lp_eop, bus.tx_lp_data});
  end
  // MSB-first 0x8005 CRC over bit-reversed input, reflected at the end
  function automatic logic [15:0] crc_ref(input logic [7:0] pl[$]);
    logic [15:0] r = 16'hFFFF, o;
    foreach (pl[k])
      for (int i = 0; i < 8; i++) r = {r[14:0], 1'b0} ^ ((r[15] ^ pl[k][i]) ? 16'h8005 : 16'h0000);
    for (int i = 0; i < 16; i++) o[i] = r[15-i];
    return o;
  endfunction
  // mode 0: full packet with CRC, 1: sop&eop single byte, 2: truncated by cancel
  function automatic cap_q_t model(input logic [7:0] pid, input logic [7:0] pl[$], input int mode);
    cap_q_t q;
    logic [15:0] c;
    q.push_back({1'b1, mode == 1, pid});
    if (mode == 1) return q;
    foreach (pl[k]) q.push_back({2'b00, pl[k]});
    if (mode == 0) begin
      c = ~crc_ref(pl);
      q.push_back({2'b00, c[7:0]});
      q.push_back({2'b01, c[15:8]});
    end
    return q;
  endfunction
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic check_cap(input string tag, input cap_q_t exp);
    chk({tag, "_len"}, 16'(cap.size()), 16'(exp.size()));
    for (int i = 0; i < exp.size() && i < cap.size(); i++) chk($sformatf("%s_b%0d", tag, i), 16'(cap[i]), 16'(exp[i]));
    cap.delete();
  endtask
  task automatic send_byte(input logic [7:0] d, input logic s, input logic e, input logic c);
    int n = 0;
    bus.tx_lt_valid = 1; bus.tx_lt_data = d; bus.tx_lt_sop = s; bus.tx_lt_eop = e; bus.tx_lt_cancle = c;
    do @(negedge clk); while (bus.tx_lt_ready !== 1'b1 && ++n < 200);
    chk("accept_timeout", 16'(n < 200), 16'd1);
    @(posedge clk); #1;
    bus.tx_lt_valid = 0; bus.tx_lt_sop = 0; bus.tx_lt_eop = 0; bus.tx_lt_cancle = 0;
  endtask
  task automatic wait_idle();
    int n = 0;
    do @(negedge clk); while (crc_busy !== 1'b0 && ++n < 200);
    chk("idle_timeout", 16'(n < 200), 16'd1);
    @(posedge clk); #1;
  endtask
  task automatic send_pkt(input logic [7:0] pid, input logic [7:0] pl[$]);
    send_byte(pid, 1, 0, 0);
    foreach (pl[k]) send_byte(pl[k], 0, k == pl.size() - 1, 0);
    wait_idle();
  endtask
  task automatic rand_pl(output logic [7:0] pl[$], input int len);
    pl.delete();
    repeat (len) pl.push_back(8'($urandom));
  endtask
  initial begin
    logic [7:0] std[$], pl[$];
    logic [15:0] c;
    for (int i = 0; i < 9; i++) std.push_back(8'h31 + 8'(i));
    bus.tx_lt_valid = 1; bus.tx_lt_sop = 1; bus.tx_lt_eop = 1; bus.tx_lt_data = 8'hAA; bus.tx_lt_cancle = 1;
    bus.tx_lp_ready = 1;
    #12;
    chk("rst_valid", 16'(bus.tx_lp_valid), 0);
    chk("rst_sop", 16'(bus.tx_lp_sop), 0);
    chk("rst_eop", 16'(bus.tx_lp_eop), 0);
    chk("rst_cancle", 16'(bus.tx_lp_cancle), 0);
    chk("rst_busy", 16'(crc_busy), 0);
    chk("rst_data", 16'(bus.tx_lp_data), 0);
    bus.tx_lt_valid = 0; bus.tx_lt_sop = 0; bus.tx_lt_eop = 0; bus.tx_lt_cancle = 0;
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1;
    send_pkt(8'hC3, std);
    chk("check_lo", 16'(cap.size() > 10 ? cap[10] : 10'h0), {6'h00, 2'b00, 8'hC8});
    chk("check_hi", 16'(cap.size() > 11 ? cap[11] : 10'h0), {6'h00, 2'b01, 8'hB4});
    check_cap("std", model(8'hC3, std, 0));
    send_byte(8'h4B, 1, 0, 0);
    bus.tx_lt_eop = 1;
    @(posedge clk); #1 bus.tx_lt_eop = 0;
    wait_idle();
    pl.delete();
    check_cap("zero_len", model(8'h4B, pl, 0));
    send_byte(8'hD2, 1, 1, 0);
    repeat (3) @(posedge clk); #1;
    check_cap("handshake", model(8'hD2, pl, 1));
    send_byte(8'h77, 0, 0, 0);
    repeat (2) @(posedge clk); #1;
    chk("idle_drop", 16'(cap.size()), 0);
    stall_en = 1;
    send_pkt(8'hC3, std);
    check_cap("std_stall", model(8'hC3, std, 0));
    for (int p = 0; p < 5; p++) begin
      rand_pl(pl, $urandom_range(1, 12));
      send_pkt(8'hC3, pl);
      check_cap($sformatf("rand%0d", p), model(8'hC3, pl, 0));
    end
    stall_en = 0;
    @(posedge clk); #1;
    rand_pl(pl, 3);
    send_byte(8'hE1, 1, 0, 0);
    foreach (pl[k]) send_byte(pl[k], 0, 0, 0);
    bus.tx_lt_valid = 1; bus.tx_lt_data = 8'h99; bus.tx_lt_eop = 1; bus.tx_lt_cancle = 1;
    @(negedge clk);
    chk("cancel_same_cycle", 16'(bus.tx_lp_cancle), 1);
    @(posedge clk); #1;
    bus.tx_lt_valid = 0; bus.tx_lt_eop = 0; bus.tx_lt_cancle = 0;
    @(negedge clk);
    chk("cancel_busy", 16'(crc_busy), 0);
    chk("cancel_release", 16'(bus.tx_lp_cancle), 0);
    @(posedge clk); #1;
    send_byte(8'h42, 0, 0, 0);
    repeat (2) @(posedge clk); #1;
    check_cap("cancel_trunc", model(8'hE1, pl, 2));
    rand_pl(pl, 7);
    send_pkt(8'h5A, pl);
    check_cap("after_cancel", model(8'h5A, pl, 0));
    rand_pl(pl, 5);
    send_byte(8'hC3, 1, 0, 0);
    foreach (pl[k]) send_byte(pl[k], 0, k == 4, 0);
    rdy_fixed = 0; bus.tx_lp_ready = 0;
    c = ~crc_ref(pl);
    @(negedge clk);
    chk("crclo_busy", 16'(crc_busy), 1);
    chk("crclo_data", 16'(bus.tx_lp_data), 16'(c[7:0]));
    cap.delete();
    #2 rst_n = 0;
    #1;
    chk("midrst_valid", 16'(bus.tx_lp_valid), 0);
    chk("midrst_eop", 16'(bus.tx_lp_eop), 0);
    chk("midrst_busy", 16'(crc_busy), 0);
    chk("midrst_data", 16'(bus.tx_lp_data), 0);
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1; rdy_fixed = 1; bus.tx_lp_ready = 1;
    repeat (10) @(posedge clk); #1;
    chk("no_crc_after_rst", 16'(cap.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/crc16_t.md
CRC16_T -- requirements
Module: crc16_t

Interface
REQ-001 SHALL provide: clk  input  1  single clock; all state on rising edge.
REQ-002 SHALL provide: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL provide upstream stream (from link layer):
- tx_lt_sop  input  1  first byte (PID) of packet
- tx_lt_eop  input  1  last payload byte
- tx_lt_valid  input  1  byte valid
- tx_lt_ready  output  1  byte accepted when valid&ready
- tx_lt_data  input  8  byte
- tx_lt_cancle  input  1  abort current packet
REQ-004 SHALL provide downstream stream (to phy side):
- tx_lp_sop  output  1
- tx_lp_eop  output  1
- tx_lp_valid  output  1
- tx_lp_ready  input  1
- tx_lp_data  output  8
- tx_lp_cancle  output  1
REQ-005 SHALL provide: crc_busy  output  1  high while in CRC_LO or CRC_HI.

Function
REQ-006 SHALL be the transmit counterpart of crc16_r: forward a DATA packet and append the 2-byte USB CRC16 after the last payload byte.
REQ-007 SHALL use CRC16: poly x^16+x^15+x^2+1, LSB-first bit order (reflected 0xA001), init 0xFFFF, transmitted value = bitwise inverse of register.
REQ-008 SHALL cover payload bytes only; PID byte (sop) excluded from CRC.
REQ-009 SHALL use FSM states IDLE, DATA, CRC_LO, CRC_HI.
REQ-010 IDLE: tx_lt_ready = tx_lp_ready; on handshake with sop=1 forward byte with tx_lp_sop=1, load CRC=0xFFFF, go DATA; if sop&eop same byte, forward with tx_lp_eop=1, no CRC appended, stay IDLE (handshake-type packet).
REQ-011 IDLE: a valid byte without sop SHALL be accepted and dropped (tx_lp_valid=0).
REQ-012 DATA: zero-latency combinational pass-through of valid/data/ready; CRC updated on each handshake; tx_lp_eop forced 0.
REQ-013 DATA: handshake with eop=1 SHALL go CRC_LO, CRC register including that byte.
REQ-014 DATA: a byte with sop=1 SHALL restart: forwarded as new PID with tx_lp_sop=1, CRC reloaded 0xFFFF.
REQ-015 CRC_LO: tx_lt_ready=0, tx_lp_valid=1, tx_lp_data=~crc[7:0]; on tx_lp_ready go CRC_HI.
REQ-016 CRC_HI: tx_lt_ready=0, tx_lp_valid=1, tx_lp_data=~crc[15:8], tx_lp_eop=1; on tx_lp_ready go IDLE.
REQ-017 Zero-length payload (eop with no payload after PID impossible by REQ-010): PID then eop-marked empty-payload handled by upstream sending sop byte without eop, then CRC SHALL be 0x0000 when DATA is left via tx_lt_cancle-free eop-only byte rule: not supported; zero-length DATA packets SHALL be signalled by sop byte plus tx_lt_eop on a zero-valid cycle — tx_lt_eop with tx_lt_valid=0 in DATA SHALL go CRC_LO with CRC unchanged.
REQ-018 Downstream data/valid SHALL hold stable while valid & !ready.
REQ-019 tx_lt_cancle in any state SHALL assert tx_lp_cancle same cycle (combinational), force next state IDLE, reload CRC 0xFFFF; cancel wins over simultaneous eop/sop.
REQ-020 No back-to-back packet acceptance while crc_busy.

Reset
REQ-021 rst_n low SHALL asynchronously force state IDLE, CRC 0xFFFF; outputs tx_lp_valid, tx_lp_sop, tx_lp_eop, tx_lp_cancle, crc_busy = 0, tx_lp_data = 0x00.
REQ-022 Reset mid-packet SHALL discard the packet; no CRC bytes emitted after release.

Structure
REQ-023 Shared package usb_pkg SHALL hold CRC16 poly (16'hA001 reflected), init 16'hFFFF, and FSM state enum.
REQ-024 One sub-module crc16_byte SHALL compute next-CRC for one byte combinationally; reusable by crc16_r.

Verification
REQ-025 PID 0xC3 then "123456789" (0x31..0x39, eop on 0x39), ready=1 -> downstream 0xC3, 0x31..0x39, 0xC8, 0xB4 (eop on 0xB4).
REQ-026 PID 0x4B then idle eop (REQ-017) -> downstream 0x4B, 0x00, 0x00 (eop on second 0x00).
REQ-027 PID 0xD2 with sop&eop -> single byte 0xD2, sop=eop=1, no CRC bytes.
REQ-028 REQ-025 stimulus with random tx_lp_ready stalls -> identical byte sequence, no drop/duplication, data stable during stall.
REQ-029 tx_lt_cancle pulse on 4th payload byte -> tx_lp_cancle same cycle, state IDLE, next packet CRC correct.
REQ-030 rst_n asserted during CRC_LO -> all outputs 0 immediately; after release no CRC_HI emitted.
